// File: rtl/data_memory_ctrl_if.sv
// rtl/data_memory_ctrl_if.sv - request/response bundle for the data memory controller
interface data_memory_ctrl_if #(
  parameter int ADDR_W = 15
);
  logic              req;
  logic              ready;
  logic              mem_write;
  logic              mem_read;
  logic [1:0]        size;
  logic              is_unsigned;
  logic [ADDR_W-1:0] address;
  logic [31:0]       write_data;
  logic [31:0]       read_data;
  logic              rvalid;
  logic              err;
  logic              init_done;

  modport master (
    output req, mem_write, mem_read, size, is_unsigned, address, write_data,
    input  ready, read_data, rvalid, err, init_done
  );

  modport slave (
    input  req, mem_write, mem_read, size, is_unsigned, address, write_data,
    output ready, read_data, rvalid, err, init_done
  );
endinterface

// File: rtl/data_memory_ctrl.sv
// rtl/data_memory_ctrl.sv - byte-addressable word memory with zero-fill, sized loads/stores
module data_memory_ctrl #(
  parameter int ADDR_W     = 15,
  parameter bit INIT_CLEAR = 1'b1
) (
  input logic               clk,
  input logic               rst_n,
  data_memory_ctrl_if.slave bus
);
  localparam int IDX_W = ADDR_W - 2;
  localparam int DEPTH = 1 << IDX_W;

  typedef enum logic {ST_INIT, ST_IDLE} state_t;
  localparam state_t RST_STATE = INIT_CLEAR ? ST_INIT : ST_IDLE;

  state_t           state_q, state_d;
  logic [IDX_W-1:0] fill_cnt_q, fill_cnt_d;
  logic [31:0]      read_data_q, read_data_d;
  logic             rvalid_q, rvalid_d;
  logic             err_q, err_d;
  logic [31:0]      mem_q [DEPTH];

  logic             accept;
  logic             bad_req;
  logic             is_load;
  logic             is_store;
  logic [IDX_W-1:0] word_idx;
  logic [1:0]       lane;
  logic [4:0]       lane_shift;
  logic [31:0]      rd_word;
  logic [31:0]      rd_shifted;
  logic [31:0]      load_val;
  logic [31:0]      st_data;
  logic [3:0]       st_be;

  logic             mem_we;
  logic [IDX_W-1:0] mem_widx;
  logic [31:0]      mem_wdata;
  logic [3:0]       mem_wbe;

  // Request decode and lane alignment
  always_comb begin
    word_idx   = bus.address[ADDR_W-1:2];
    lane       = bus.address[1:0];
    lane_shift = {lane, 3'b000};
    accept     = bus.req && (state_q == ST_IDLE);
    bad_req    = (bus.size == 2'b11)
              || (bus.size == 2'b01 && lane[0])
              || (bus.size == 2'b10 && lane != 2'b00)
              || (bus.mem_read == bus.mem_write);
    is_load    = accept && !bad_req && bus.mem_read;
    is_store   = accept && !bad_req && bus.mem_write;

    st_data = bus.write_data << lane_shift;
    case (bus.size)
      2'b00:   st_be = 4'b0001 << lane;
      2'b01:   st_be = 4'b0011 << lane;
      2'b10:   st_be = 4'b1111;
      default: st_be = 4'b0000;
    endcase

    rd_word    = mem_q[word_idx];
    rd_shifted = rd_word >> lane_shift;
    case (bus.size)
      2'b00:   load_val = bus.is_unsigned ? {24'h0, rd_shifted[7:0]}
                                          : {{24{rd_shifted[7]}}, rd_shifted[7:0]};
      2'b01:   load_val = bus.is_unsigned ? {16'h0, rd_shifted[15:0]}
                                          : {{16{rd_shifted[15]}}, rd_shifted[15:0]};
      default: load_val = rd_word;
    endcase
  end

  // The fill sequence owns the write port while in INIT
  always_comb begin
    mem_we    = 1'b0;
    mem_widx  = word_idx;
    mem_wdata = st_data;
    mem_wbe   = st_be;
    if (state_q == ST_INIT) begin
      mem_we    = 1'b1;
      mem_widx  = fill_cnt_q;
      mem_wdata = 32'h0;
      mem_wbe   = 4'hF;
    end else if (is_store) begin
      mem_we = 1'b1;
    end
  end

  always_comb begin
    state_d     = state_q;
    fill_cnt_d  = fill_cnt_q;
    read_data_d = read_data_q;
    rvalid_d    = 1'b0;
    err_d       = 1'b0;
    case (state_q)
      ST_INIT: begin
        fill_cnt_d = fill_cnt_q + 1'b1;
        if (fill_cnt_q == {IDX_W{1'b1}}) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        if (accept) begin
          err_d = bad_req;
        end
        if (is_load) begin
          rvalid_d    = 1'b1;
          read_data_d = load_val;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= RST_STATE;
      fill_cnt_q  <= '0;
      read_data_q <= 32'h0;
      rvalid_q    <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      fill_cnt_q  <= fill_cnt_d;
      read_data_q <= read_data_d;
      rvalid_q    <= rvalid_d;
      err_q       <= err_d;
    end
  end

  // Storage array carries no reset; contents are defined only by the fill or by stores
  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int b = 0; b < 4; b++) begin
        if (mem_wbe[b]) begin
          mem_q[mem_widx][8*b +: 8] <= mem_wdata[8*b +: 8];
        end
      end
    end
  end

  assign bus.ready     = rst_n && (state_q == ST_IDLE);
  assign bus.init_done = rst_n && (state_q == ST_IDLE);
  assign bus.read_data = read_data_q;
  assign bus.rvalid    = rvalid_q;
  assign bus.err       = err_q;
endmodule

// File: doc/data_memory_ctrl.md
DATA_MEMORY_CTRL -- requirements
Module: data_memory_ctrl

Interface
REQ-001 Parameter ADDR_W, default 15, byte-address width; memory holds 2^(ADDR_W-2) 32-bit words (32 KB by default).
REQ-002 Parameter INIT_CLEAR, default 1; 1 runs the zero-fill sequence after reset, 0 skips it.
REQ-003 Clk  input  1  single clock; all state updates on the rising edge.
REQ-004 Rst_n  input  1  reset, asynchronous and active-low.
REQ-005 Req  input  1  access request, qualified by Ready.
REQ-006 Ready  output  1  block can accept a request this cycle.
REQ-007 MemWrite  input  1  request is a store.
REQ-008 MemRead  input  1  request is a load.
REQ-009 Size  input  2  access size: 00 byte, 01 halfword, 10 word, 11 illegal.
REQ-010 Unsigned  input  1  load extension: 1 zero-extend, 0 sign-extend.
REQ-011 Address  input  ADDR_W  byte address.
REQ-012 Write_data  input  32  store data, right-aligned (byte in [7:0], halfword in [15:0]).
REQ-013 Read_data  output  32  load result, registered.
REQ-014 Rvalid  output  1  Read_data valid, one-cycle pulse.
REQ-015 Err  output  1  access rejected, one-cycle pulse.
REQ-016 Init_done  output  1  zero-fill complete; stays high until the next reset.

Function
REQ-017 The block SHALL use two states, INIT and IDLE; Ready SHALL be 1 only in IDLE.
REQ-018 In INIT the block SHALL write zero to word index 0, 1, ... DEPTH-1, one word per cycle, then enter IDLE with Init_done=1 on the following cycle.
REQ-019 When INIT_CLEAR=0, reset release SHALL go directly to IDLE with Init_done=1, and memory contents SHALL be undefined.
REQ-020 An access SHALL be accepted on a rising edge where Req=1 and Ready=1; inputs SHALL be ignored in all other cycles.
REQ-021 Byte lanes SHALL be little-endian: byte Address[1:0]=n occupies bits [8n+7:8n] of word Address[ADDR_W-1:2].
REQ-022 An accepted store SHALL update only the addressed lanes on the accepting edge; all other lanes SHALL be unchanged.
REQ-023 An accepted load SHALL produce Read_data and a one-cycle Rvalid=1 on the edge following acceptance, giving one cycle of latency.
REQ-024 Load data SHALL be the addressed byte or halfword, shifted to bit 0 and extended per Unsigned; word loads SHALL return the word unmodified.
REQ-025 Ready SHALL remain 1 in IDLE, so loads and stores may be issued back-to-back every cycle.
REQ-026 A load issued the cycle after a store to the same word SHALL return the newly written data.
REQ-027 A request SHALL be an error, with no memory access, when any of these hold: Size=11; Size=01 with Address[0]=1; Size=10 with Address[1:0]!=00; MemRead=MemWrite=1; MemRead=MemWrite=0.
REQ-028 An errored request SHALL pulse Err=1 on the edge following acceptance, with Rvalid=0 and Read_data unchanged.
REQ-029 Read_data SHALL hold its last value while Rvalid=0.

Reset
REQ-030 While Rst_n=0 the outputs SHALL be: Ready=0, Rvalid=0, Err=0, Init_done=0, Read_data=0, and the fill counter SHALL be 0.
REQ-031 After Rst_n rises the block SHALL enter INIT (INIT_CLEAR=1) or IDLE (INIT_CLEAR=0).
REQ-032 Reset asserted during INIT SHALL abort the fill; the fill SHALL restart from word 0 after release.
REQ-033 Reset asserted in the cycle after a load is accepted SHALL suppress that load's Rvalid.

Verification
REQ-034 Zero-fill: with ADDR_W=6, release reset -> Ready=0 for exactly 16 cycles, then Ready=1 and Init_done=1; word loads of addresses 0x00..0x3C all return 0.
REQ-035 Byte/half store and extension: store word 0x11223344 to 0x10; store byte 0xAB to 0x12; signed load byte 0x12 -> 0xFFFFFFAB; unsigned load byte 0x12 -> 0x000000AB; unsigned load half 0x10 -> 0x00003344; word load 0x10 -> 0x11AB3344.
REQ-036 Back-to-back: store 0xDEADBEEF to 0x20, then load word 0x20 the next cycle -> Rvalid=1 one cycle later with Read_data=0xDEADBEEF, and Ready never drops.
REQ-037 Errors: each of these gives Err=1 for one cycle and leaves memory unchanged: half load at 0x11; word store at 0x22; Size=11; MemRead=MemWrite=1. Verify by a following word load at 0x20 returning its previous value.
REQ-038 Reset mid-fill: with ADDR_W=6, drop Rst_n at fill cycle 8 -> all outputs go to reset values immediately; after release the fill takes a full 16 cycles.
REQ-039 Pipelined loads: load words 0x00, 0x04, 0x08 on consecutive cycles -> three consecutive Rvalid pulses carrying the data in issue order.
